// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton
//   Registered 1-to-NCH stream demultiplexer with valid/ready flow control.
//   Each accepted beat is steered to the output slot picked by in_sel.
//   When PKT_MODE=1, the channel chosen by the first beat of a packet is locked
//   until the in_last beat. A beat with a bad select is consumed and dropped,
//   and it is reported on sel_err/err_cnt. A packet that starts with a bad
//   select is dropped as a whole.
//
//   Ports
//     clk, rst_n     clock and asynchronous active-low reset
//     in_valid       input beat valid
//     in_ready       input beat accepted when in_valid & in_ready
//     in_data        input payload (WIDTH bits)
//     in_last        last beat of a packet; also stored in out_last
//     in_sel         destination channel (SELW bits)
//     out_valid      per-channel valid (NCH bits)
//     out_ready      per-channel ready (NCH bits)
//     out_data       channel k occupies out_data[k*WIDTH +: WIDTH]
//     out_last       per-channel last flag
//     sel_err        one-cycle pulse after a bad beat or packet start is accepted
//     err_cnt        saturating count of sel_err pulses
//     busy           FSM is inside a locked or dropped packet
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | between packets; in_sel is sampled on every beat
//   ST_PKT  | inside a good packet; beats follow the locked select
//   ST_DROP | inside a bad packet; beats are consumed until in_last
module stream_demux_1ton #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int SELW     = 2,
    parameter int PKT_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    input  logic [SELW-1:0]      in_sel,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_last,
    output logic                 sel_err,
    output logic [7:0]           err_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] lock_q, lock_d;
    logic [SELW-1:0] eff_sel;
    logic            sample_sel;
    logic            bad_sel;
    logic            sel_free;
    logic            accept;
    logic            sel_err_d;
    logic [NCH-1:0]  slot_free;
    logic [NCH-1:0]  load;

    // A slot can take a new beat in the same cycle that it drains.
    assign slot_free = ~out_valid | out_ready;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        sample_sel = (PKT_MODE == 0) || (state_q == ST_IDLE);
        eff_sel    = sample_sel ? in_sel : lock_q;
        // An X/Z select is treated as bad. Synthesis folds $isunknown to 0.
        // The locked select is always a good channel, so it is not checked.
        bad_sel    = sample_sel &&
                     ($isunknown(in_sel) || (32'(eff_sel) >= 32'(NCH)));

        // Look up slot_free through a compare loop. This avoids indexing past
        // NCH when 2**SELW > NCH.
        sel_free = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (eff_sel == SELW'(k)) sel_free = slot_free[k];
        end

        in_ready = (state_q == ST_DROP) || bad_sel || sel_free;
        accept   = in_valid && in_ready;

        load      = '0;
        state_d   = state_q;
        lock_d    = lock_q;
        sel_err_d = 1'b0;

        if (accept) begin
            if (state_q == ST_DROP) begin
                if (in_last) state_d = ST_IDLE;
            end else if (bad_sel) begin
                sel_err_d = 1'b1;
                if ((PKT_MODE != 0) && !in_last) state_d = ST_DROP;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (eff_sel == SELW'(k)) load[k] = 1'b1;
                end
                if (PKT_MODE != 0) begin
                    if ((state_q == ST_IDLE) && !in_last) begin
                        state_d = ST_PKT;
                        lock_d  = in_sel;
                    end else if ((state_q == ST_PKT) && in_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lock_q    <= '0;
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
            sel_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            sel_err <= sel_err_d;
            if (sel_err_d && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            for (int k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    out_valid[k]                <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]  <= in_data;
                    out_last[k]                 <= in_last;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton
//   Drives three instances from shared inputs:
//     u_a  NCH=4, PKT_MODE=0
//     u_b  NCH=4, PKT_MODE=1
//     u_c  NCH=3, PKT_MODE=1
//   A behavioural model tracks each instance's slots, packet phase and error
//   count. Every cycle, every output is compared against that model.
module tb_stream_demux_1ton;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic [1:0] in_sel = 2'd0;
    logic [3:0] out_ready = 4'hF;

    logic [NI-1:0] in_ready, sel_err, busy;
    logic [3:0]  ov_a, ov_b, ol_a, ol_b;
    logic [2:0]  ov_c, ol_c;
    logic [31:0] od_a, od_b;
    logic [23:0] od_c;
    logic [7:0]  ec_a, ec_b, ec_c;

    logic [NI-1:0][3:0]  ov_all, ol_all;
    logic [NI-1:0][31:0] od_all;
    logic [NI-1:0][7:0]  ec_all;

    assign ov_all[0] = ov_a;
    assign ov_all[1] = ov_b;
    assign ov_all[2] = {1'b0, ov_c};
    assign ol_all[0] = ol_a;
    assign ol_all[1] = ol_b;
    assign ol_all[2] = {1'b0, ol_c};
    assign od_all[0] = od_a;
    assign od_all[1] = od_b;
    assign od_all[2] = {8'h00, od_c};
    assign ec_all[0] = ec_a;
    assign ec_all[1] = ec_b;
    assign ec_all[2] = ec_c;

    always #5 clk = ~clk;

    stream_demux_1ton #(.WIDTH(8), .NCH(4), .SELW(2), .PKT_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a),
        .sel_err(sel_err[0]), .err_cnt(ec_a), .busy(busy[0]));

    stream_demux_1ton #(.WIDTH(8), .NCH(4), .SELW(2), .PKT_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_last(ol_b),
        .sel_err(sel_err[1]), .err_cnt(ec_b), .busy(busy[1]));

    stream_demux_1ton #(.WIDTH(8), .NCH(3), .SELW(2), .PKT_MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
        .out_valid(ov_c), .out_ready(out_ready[2:0]), .out_data(od_c), .out_last(ol_c),
        .sel_err(sel_err[2]), .err_cnt(ec_c), .busy(busy[2]));

    int checks = 0;
    int failures = 0;

    // Reference model. Packet phase: 0 = between packets, 1 = in good packet,
    // 2 = discarding a bad packet.
    bit         mval  [NI][4];
    logic [7:0] mdata [NI][4];
    logic       mlast [NI][4];
    int         mphase[NI];
    int         mlock [NI];
    int         merr  [NI];
    bit         mserr [NI];
    bit         mrdy  [NI];
    bit         mbad  [NI];
    int         meff  [NI];

    function automatic int nch_of(int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic bit pkt_of(int i);
        return (i != 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++) begin
                mval[i][k]  = 1'b0;
                mdata[i][k] = 8'h00;
                mlast[i][k] = 1'b0;
            end
            mphase[i] = 0;
            mlock[i]  = 0;
            merr[i]   = 0;
            mserr[i]  = 1'b0;
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the
    // rising edge. The caller changes the inputs 1 time unit after the edge.
    task automatic step();
        logic [31:0] eov, eol, eod;
        bit samp;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            samp    = !pkt_of(i) || (mphase[i] == 0);
            meff[i] = samp ? int'(in_sel) : mlock[i];
            mbad[i] = samp && ($isunknown(in_sel) || meff[i] >= nch_of(i));
            mrdy[i] = (mphase[i] == 2) || mbad[i] || !mval[i][meff[i]] || out_ready[meff[i]];
            eov = '0; eol = '0; eod = '0;
            for (int k = 0; k < nch_of(i); k++) begin
                eov[k]         = mval[i][k];
                eol[k]         = mlast[i][k];
                eod[k*8 +: 8]  = mdata[i][k];
            end
            check($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(mrdy[i]));
            check($sformatf("out_valid[%0d]", i), 32'(ov_all[i]), eov);
            check($sformatf("out_last[%0d]", i), 32'(ol_all[i]), eol);
            check($sformatf("out_data[%0d]", i), od_all[i], eod);
            check($sformatf("sel_err[%0d]", i), 32'(sel_err[i]), 32'(mserr[i]));
            check($sformatf("err_cnt[%0d]", i), 32'(ec_all[i]), 32'(merr[i]));
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(mphase[i] != 0));
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++)
                if (mval[i][k] && out_ready[k]) mval[i][k] = 1'b0;
            mserr[i] = 1'b0;
            if (in_valid && mrdy[i]) begin
                if (mphase[i] == 2) begin
                    if (in_last) mphase[i] = 0;
                end else if (mbad[i]) begin
                    mserr[i] = 1'b1;
                    if (merr[i] < 255) merr[i]++;
                    if (pkt_of(i) && !in_last) mphase[i] = 2;
                end else begin
                    mval[i][meff[i]]  = 1'b1;
                    mdata[i][meff[i]] = in_data;
                    mlast[i][meff[i]] = in_last;
                    if (pkt_of(i)) begin
                        if (mphase[i] == 0 && !in_last) begin
                            mphase[i] = 1;
                            mlock[i]  = meff[i];
                        end else if (mphase[i] == 1 && in_last) begin
                            mphase[i] = 0;
                        end
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [1:0] xsel;
        xsel = 2'bx0;

        // Reset state
        #12;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_valid[%0d]", i), 32'(ov_all[i]), 32'd0);
            check($sformatf("rst_data[%0d]", i), od_all[i], 32'd0);
            check($sformatf("rst_err[%0d]", i), 32'(ec_all[i]), 32'd0);
            check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beats to each channel, all sinks ready
        for (int k = 0; k < 4; k++) begin
            drive(2'(k), 8'hA0 + 8'(k), 1'b1);
            check("t1_onehot", 32'(ov_a), 32'(4'b0001 << k));
        end
        idle();
        check("t1_data", od_a, 32'hA3A2A1A0);

        // Back-pressure on channel 2
        out_ready = 4'b1011;
        drive(2'd2, 8'h11, 1'b1);
        drive(2'd2, 8'h22, 1'b1);
        drive(2'd2, 8'h22, 1'b1);
        out_ready = 4'b1111;
        drive(2'd2, 8'h22, 1'b1);
        check("t2_refill", 32'(od_b[23:16]), 32'h22);
        idle();

        // Locked packet: in_sel changes after the first beat
        drive(2'd1, 8'h31, 1'b0);
        drive(2'd3, 8'h32, 1'b0);
        drive(2'd3, 8'h33, 1'b1);
        check("t3_ch1", 32'(od_b[15:8]), 32'h33);
        idle();

        // Bad packets: out-of-range select, then X in the select
        drive(2'd3, 8'h41, 1'b0);
        drive(2'd3, 8'h42, 1'b1);
        drive(xsel, 8'h43, 1'b0);
        drive(xsel, 8'h44, 1'b1);
        idle();
        idle();

        // Async reset mid-packet while ch0 is held
        out_ready = 4'b1110;
        drive(2'd0, 8'h55, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("arst_valid[%0d]", i), 32'(ov_all[i]), 32'd0);
            check($sformatf("arst_busy[%0d]", i), 32'(busy[i]), 32'd0);
        end
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        drive(2'd2, 8'h77, 1'b1);
        check("t5_ch2", 32'(ov_c), 32'b100);
        idle();

        // Saturate the error counter on the 3-channel instance
        for (int n = 0; n < 300; n++)
            drive(2'd3, 8'($urandom), 1'b1);
        idle();
        check("t6_sat", 32'(ec_c), 32'hFF);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            in_sel    = 2'($urandom);
            out_ready = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
